spdif_frame_decoder: RTL and testbench

- S/PDIF receiver. Recovers sub-frames from the biphase-mark line spdif_in, oversampled by clk.
- Delivers one audio sample per sub-frame on a valid/ready stream carrying left/right tag and error flag.
- Sits at the input of the effect chain, ahead of the dual-clock buffer into the processing domain.
- No PLL; interval measurement only.

---
 rtl/spdif_pkg.sv | 27 ++
 rtl/spdif_biphase_slicer.sv | 61 ++++++
 rtl/spdif_frame_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_spdif_frame_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Shared types and slot constants for the S/PDIF sub-frame decoder.
package spdif_pkg;

  typedef enum logic [1:0] {PRE_NONE, PRE_B, PRE_M, PRE_W} pre_t;
  typedef enum logic [1:0] {IV_1UI, IV_2UI, IV_3UI, IV_BAD} iv_t;

  localparam int SLOT_AUDIO_LSB = 4;
  localparam int SLOT_AUDIO_MSB = 27;
  localparam int SLOT_V         = 28;
  localparam int SLOT_U         = 29;
  localparam int SLOT_C         = 30;
  localparam int SLOT_P         = 31;

  typedef logic [1:0] state_t;
  localparam state_t ST_HUNT = 2'd0;
  localparam state_t ST_PRE  = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  // The three intervals that follow the leading 3UI of a preamble identify it.
  function automatic pre_t classify_pre(input iv_t a, input iv_t b, input iv_t c);
    if (a == IV_1UI && b == IV_1UI && c == IV_3UI) return PRE_B;
    if (a == IV_3UI && b == IV_1UI && c == IV_1UI) return PRE_M;
    if (a == IV_2UI && b == IV_1UI && c == IV_2UI) return PRE_W;
    return PRE_NONE;
  endfunction

endpackage

// File: rtl/spdif_biphase_slicer.sv
// Line front end: synchronizer, edge detect, interval counter and interval
// classifier. Emits a one-cycle strobe with the class of each completed
// interval, or a single IV_BAD strobe when the line stays quiet too long.
module spdif_biphase_slicer
  import spdif_pkg::*;
#(
  parameter int half_cell_clocks = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic spdif_in,
  output logic iv_stb,
  output iv_t  iv_class
);

  localparam int H     = half_cell_clocks;
  localparam int LIMIT = (7 * H + 1) / 2;
  localparam int CW    = $clog2(LIMIT + 1);

  logic          sync_p0, sync_p1, sync_p2;
  logic [CW-1:0] cnt;
  logic          edge_det, timeout;

  // Thresholds are compared on doubled counts so that H/2, 1.5H, 2.5H and
  // 3.5H stay exact for odd H.
  function automatic iv_t classify(input logic [CW-1:0] n);
    int n2;
    n2 = 2 * int'(n);
    if (n2 < H)     return IV_BAD;
    if (n2 < 3 * H) return IV_1UI;
    if (n2 < 5 * H) return IV_2UI;
    if (n2 < 7 * H) return IV_3UI;
    return IV_BAD;
  endfunction

  // Synchronize the line, keep the previous level, and time the gap since the
  // last edge; the counter parks at LIMIT so a dead line reports only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      cnt     <= CW'(LIMIT);
    end else begin
      // stage p0/p1: metastability filter; stage p2: previous level
      sync_p0 <= spdif_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      if (edge_det)
        cnt <= CW'(1);
      else if (cnt != CW'(LIMIT))
        cnt <= cnt + 1'b1;
    end
  end

  assign edge_det = sync_p1 ^ sync_p2;
  assign timeout  = !edge_det && (cnt == CW'(LIMIT - 1));
  assign iv_stb   = edge_det | timeout;
  assign iv_class = edge_det ? classify(cnt) : IV_BAD;

endmodule

// File: rtl/spdif_frame_decoder.sv
// S/PDIF sub-frame decoder: preamble/data FSM, slot shift register, lock
// tracking and a single-entry valid/ready output stage.
// Optional channel-status capture: define SPDIF_DECODER_CHANNEL_STATUS_EN.
module spdif_frame_decoder
  import spdif_pkg::*;
#(
  parameter int audio_width      = 16,
  parameter int half_cell_clocks = 4,
  parameter int lock_count       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spdif_in,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [audio_width-1:0] o_audio,
  output logic                   o_is_left,
  output logic                   o_is_error,
  output logic                   o_block_start,
  output logic                   o_overrun,
  output logic                   o_locked
`ifdef SPDIF_DECODER_CHANNEL_STATUS_EN
  ,
  output logic [31:0]            o_channel_status,
  output logic                   o_cs_valid
`endif
);

  localparam int LW = $clog2(lock_count + 1);

  iv_t           iv_class;
  logic          iv_stb;
  state_t        state;
  logic [1:0]    pre_idx;
  iv_t           pre_a, pre_b;
  pre_t          pre_kind;
  logic [4:0]    slot;
  logic          half;
  logic          par;
  logic [27:0]   sr;
  logic [27:0]   word;
  logic [LW-1:0] good_cnt;
  logic          bit_stb, bit_val, violation, done;

  spdif_biphase_slicer #(.half_cell_clocks(half_cell_clocks)) u_slicer (
    .clk      (clk),
    .reset    (reset),
    .spdif_in (spdif_in),
    .iv_stb   (iv_stb),
    .iv_class (iv_class)
  );

  // Turn each interval into a decoded bit or a violation for the current state.
  always_comb begin
    bit_stb   = 1'b0;
    bit_val   = 1'b0;
    violation = 1'b0;
    if (iv_stb) begin
      if (iv_class == IV_BAD) begin
        violation = 1'b1;
      end else if (state == ST_DATA) begin
        case (iv_class)
          IV_2UI: begin
            if (half) violation = 1'b1;
            else      bit_stb   = 1'b1;
          end
          IV_1UI: begin
            if (half) begin
              bit_stb = 1'b1;
              bit_val = 1'b1;
            end
          end
          default: violation = 1'b1;
        endcase
      end else if (state == ST_PRE) begin
        if (pre_idx == 2'd0 && iv_class != IV_3UI)
          violation = 1'b1;
        else if (pre_idx == 2'd3 && classify_pre(pre_a, pre_b, iv_class) == PRE_NONE)
          violation = 1'b1;
      end
    end
  end

  // word[i] holds slot i+4 once the final bit is shifted in.
  assign word = {bit_val, sr[27:1]};
  assign done = bit_stb && (slot == 5'(SLOT_P));

  // Sub-frame FSM. pre_idx 0 expects the leading 3UI that follows slot 31;
  // entering from HUNT that 3UI has already been seen, so collection starts at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_HUNT;
      pre_idx  <= 2'd0;
      pre_a    <= IV_BAD;
      pre_b    <= IV_BAD;
      pre_kind <= PRE_NONE;
      slot     <= 5'd0;
      half     <= 1'b0;
      par      <= 1'b0;
      good_cnt <= '0;
    end else if (violation) begin
      state    <= ST_HUNT;
      half     <= 1'b0;
      good_cnt <= '0;
    end else if (iv_stb) begin
      case (state)
        ST_HUNT: begin
          if (iv_class == IV_3UI) begin
            state   <= ST_PRE;
            pre_idx <= 2'd1;
          end
        end
        ST_PRE: begin
          pre_idx <= pre_idx + 2'd1;
          if (pre_idx == 2'd1) pre_a <= iv_class;
          if (pre_idx == 2'd2) pre_b <= iv_class;
          if (pre_idx == 2'd3) begin
            pre_kind <= classify_pre(pre_a, pre_b, iv_class);
            state    <= ST_DATA;
            slot     <= 5'(SLOT_AUDIO_LSB);
            half     <= 1'b0;
            par      <= 1'b0;
          end
        end
        ST_DATA: begin
          half <= (iv_class == IV_1UI) && !half;
          if (bit_stb) begin
            par  <= par ^ bit_val;
            slot <= slot + 5'd1;
          end
          if (done) begin
            state   <= ST_PRE;
            pre_idx <= 2'd0;
            if (!(par ^ bit_val) && good_cnt != LW'(lock_count))
              good_cnt <= good_cnt + 1'b1;
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  // Slot shift register, LSB (slot 4) first.
  always_ff @(posedge clk) begin
    if (bit_stb) sr <= word;
  end

  // Output stage: a fresh sub-frame always loads, overwriting an unaccepted one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid       <= 1'b0;
      o_audio       <= '0;
      o_is_left     <= 1'b0;
      o_is_error    <= 1'b0;
      o_block_start <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_overrun <= done && o_valid && !o_ready;
      if (done) begin
        o_valid       <= 1'b1;
        o_audio       <= word[SLOT_AUDIO_MSB-SLOT_AUDIO_LSB -: audio_width];
        o_is_left     <= (pre_kind != PRE_W);
        o_block_start <= (pre_kind == PRE_B);
        o_is_error    <= (par ^ bit_val) | word[SLOT_V-SLOT_AUDIO_LSB];
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_locked = (good_cnt >= LW'(lock_count));

`ifdef SPDIF_DECODER_CHANNEL_STATUS_EN
  logic [31:0] cs_sr;
  logic [4:0]  cs_cnt;
  logic        cs_active;

  // Collect C bits from the left sub-frames of a block, starting at B.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_channel_status <= '0;
      o_cs_valid       <= 1'b0;
      cs_sr            <= '0;
      cs_cnt           <= '0;
      cs_active        <= 1'b0;
    end else begin
      o_cs_valid <= 1'b0;
      if (violation) begin
        cs_active <= 1'b0;
      end else if (done && pre_kind == PRE_B) begin
        cs_sr     <= {31'd0, word[SLOT_C-SLOT_AUDIO_LSB]};
        cs_cnt    <= 5'd1;
        cs_active <= 1'b1;
      end else if (done && pre_kind == PRE_M && cs_active) begin
        cs_sr[cs_cnt] <= word[SLOT_C-SLOT_AUDIO_LSB];
        cs_cnt        <= cs_cnt + 5'd1;
        if (cs_cnt == 5'd31) begin
          o_channel_status <= {word[SLOT_C-SLOT_AUDIO_LSB], cs_sr[30:0]};
          o_cs_valid       <= 1'b1;
          cs_active        <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spdif_frame_decoder.sv
// Scoreboard bench for spdif_frame_decoder: directed biphase-mark streams,
// expected samples queued at stimulus time and checked by a monitor.
`timescale 1ns/1ps
module tb_spdif_frame_decoder;
  import spdif_pkg::*;

  localparam int AW = 16;
  localparam int H  = 4;
  localparam int LC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          spdif_in = 1'b0;
  logic          o_ready = 1'b1;
  logic          o_valid, o_is_left, o_is_error, o_block_start, o_overrun, o_locked;
  logic [AW-1:0] o_audio;
`ifdef SPDIF_DECODER_CHANNEL_STATUS_EN
  logic [31:0]   o_channel_status;
  logic          o_cs_valid;
`endif

  typedef struct packed {
    logic [AW-1:0] audio;
    logic          is_left;
    logic          is_error;
    logic          block_start;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ovr = 0;

  always #5 clk = ~clk;

  spdif_frame_decoder #(
    .audio_width      (AW),
    .half_cell_clocks (H),
    .lock_count       (LC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .spdif_in         (spdif_in),
    .o_valid          (o_valid),
    .o_ready          (o_ready),
    .o_audio          (o_audio),
    .o_is_left        (o_is_left),
    .o_is_error       (o_is_error),
    .o_block_start    (o_block_start),
    .o_overrun        (o_overrun),
    .o_locked         (o_locked)
`ifdef SPDIF_DECODER_CHANNEL_STATUS_EN
    ,
    .o_channel_status (o_channel_status),
    .o_cs_valid       (o_cs_valid)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted transfer must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (o_overrun) n_ovr++;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_sample: got %0h required none", o_audio);
        end else begin
          e = exp_q.pop_front();
          check("sample{audio,left,err,blk}",
                32'({o_audio, o_is_left, o_is_error, o_block_start}), 32'(e));
        end
      end
    end
  end

  task automatic push(input logic [AW-1:0] a, input logic l, input logic e, input logic b);
    exp_t x;
    x.audio = a;
    x.is_left = l;
    x.is_error = e;
    x.block_start = b;
    exp_q.push_back(x);
  endtask

  // 28-bit slot word: {P, C, U, V, audio[23:0]}, P makes even parity unless flipped.
  function automatic logic [27:0] mk(input logic [23:0] a, input logic v, input logic pflip);
    logic [27:0] w;
    w = {1'b0, 1'b0, 1'b0, v, a};
    w[27] = (^w[26:0]) ^ pflip;
    return w;
  endfunction

  // One line interval: toggle, then hold n half-cells (optionally +-1 clk).
  task automatic iv(input int n, input bit jit);
    int w;
    w = n * H;
    if (jit) w = w + int'($urandom_range(2)) - 1;
    spdif_in = ~spdif_in;
    repeat (w) @(posedge clk);
    #1;
  endtask

  task automatic send_sub(input pre_t p, input logic [27:0] w, input int first,
                          input int last, input bit jit);
    if (first == 0) begin
      case (p)
        PRE_B:   begin iv(3, jit); iv(1, jit); iv(1, jit); iv(3, jit); end
        PRE_M:   begin iv(3, jit); iv(3, jit); iv(1, jit); iv(1, jit); end
        default: begin iv(3, jit); iv(2, jit); iv(1, jit); iv(2, jit); end
      endcase
    end
    for (int s = (first < 4) ? 4 : first; s <= last; s++) begin
      if (w[s-4]) begin
        iv(1, jit);
        iv(1, jit);
      end else begin
        iv(2, jit);
      end
    end
  endtask

  // Closing edge completes the last sub-frame; lock is read before the idle
  // line times out, then the line is left idle.
  task automatic close(input logic lock_req, input string name);
    spdif_in = ~spdif_in;
    repeat (8) @(posedge clk);
    #1;
    check(name, 32'(o_locked), 32'(lock_req));
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_audio"}, 32'(o_audio), 0);
    check({tag, "_left"},  32'(o_is_left), 0);
    check({tag, "_error"}, 32'(o_is_error), 0);
    check({tag, "_block"}, 32'(o_block_start), 0);
    check({tag, "_ovr"},   32'(o_overrun), 0);
    check({tag, "_lock"},  32'(o_locked), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Basic left/right pair plus a V=1 sub-frame
    push(16'h1234, 1'b1, 1'b0, 1'b1); send_sub(PRE_B, mk(24'h123400, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'hABCD, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'hABCD00, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'h00FF, 1'b1, 1'b1, 1'b0); send_sub(PRE_M, mk(24'h00FF00, 1'b1, 1'b0), 0, 31, 1'b0);
    close(1'b0, "t1_locked");

    // Bad parity on the left sub-frame: flagged and not counted toward lock
    push(16'h1234, 1'b1, 1'b1, 1'b1); send_sub(PRE_B, mk(24'h123400, 1'b0, 1'b1), 0, 31, 1'b0);
    push(16'hABCD, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'hABCD00, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'h5678, 1'b1, 1'b0, 1'b0); send_sub(PRE_M, mk(24'h567800, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'h9ABC, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'h9ABC00, 1'b0, 1'b0), 0, 31, 1'b0);
    close(1'b0, "t2_locked_3_good");
    push(16'h1234, 1'b1, 1'b0, 1'b1); send_sub(PRE_B, mk(24'h123400, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'hABCD, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'hABCD00, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'h5678, 1'b1, 1'b0, 1'b0); send_sub(PRE_M, mk(24'h567800, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'h9ABC, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'h9ABC00, 1'b0, 1'b0), 0, 31, 1'b0);
    close(1'b1, "t2_locked_4_good");

    // Inverted line polarity
    spdif_in = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    push(16'h1234, 1'b1, 1'b0, 1'b1); send_sub(PRE_B, mk(24'h123400, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'hABCD, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'hABCD00, 1'b0, 1'b0), 0, 31, 1'b0);
    close(1'b0, "t3_locked");

    // Back-pressure across three sub-frames: two overruns, last one held
    o_ready = 1'b0;
    n_ovr = 0;
    push(16'h3333, 1'b1, 1'b0, 1'b0);
    send_sub(PRE_B, mk(24'h111100, 1'b0, 1'b0), 0, 31, 1'b0);
    send_sub(PRE_W, mk(24'h222200, 1'b0, 1'b0), 0, 31, 1'b0);
    send_sub(PRE_M, mk(24'h333300, 1'b0, 1'b0), 0, 31, 1'b0);
    close(1'b0, "t4_locked");
    check("t4_overrun_pulses", n_ovr, 2);
    check("t4_held_valid", 32'(o_valid), 1);
    check("t4_held_audio", 32'(o_audio), 'h3333);
    o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t4_valid_after_transfer", 32'(o_valid), 0);
    check("t4_queue_drained", exp_q.size(), 0);

    // Lock, lose it on a dead line mid-DATA, relock
    push(16'hC001, 1'b1, 1'b0, 1'b1); send_sub(PRE_B, mk(24'hC00100, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'hC002, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'hC00200, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'hC003, 1'b1, 1'b0, 1'b0); send_sub(PRE_M, mk(24'hC00300, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'hC004, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'hC00400, 1'b0, 1'b0), 0, 31, 1'b0);
    send_sub(PRE_M, mk(24'hDEAD00, 1'b0, 1'b0), 0, 14, 1'b0);
    check("t5_locked_before_drop", 32'(o_locked), 1);
    repeat (24) @(posedge clk);
    #1;
    check("t5_locked_after_drop", 32'(o_locked), 0);
    push(16'h0A01, 1'b1, 1'b0, 1'b1); send_sub(PRE_B, mk(24'h0A0100, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'h0A02, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'h0A0200, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'h0A03, 1'b1, 1'b0, 1'b0); send_sub(PRE_M, mk(24'h0A0300, 1'b0, 1'b0), 0, 31, 1'b0);
    push(16'h0A04, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'h0A0400, 1'b0, 1'b0), 0, 31, 1'b0);
    close(1'b1, "t5_relocked");

    // Reset in the middle of slot 15 with a held sample pending
    o_ready = 1'b0;
    send_sub(PRE_B, mk(24'h777700, 1'b0, 1'b0), 0, 31, 1'b0);
    send_sub(PRE_W, mk(24'h888800, 1'b0, 1'b0), 0, 14, 1'b0);
    spdif_in = ~spdif_in;
    repeat (2) @(posedge clk);
    #1;
    check("t6_valid_before_reset", 32'(o_valid), 1);
    reset = 1'b0;
    #1;
    check_zero("t6_reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    o_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    // Jittered stream after reset
    push(16'h4321, 1'b1, 1'b0, 1'b1); send_sub(PRE_B, mk(24'h432100, 1'b0, 1'b0), 0, 31, 1'b1);
    push(16'h8765, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'h876500, 1'b0, 1'b0), 0, 31, 1'b1);
    push(16'hFFFF, 1'b1, 1'b0, 1'b0); send_sub(PRE_M, mk(24'hFFFFFF, 1'b0, 1'b0), 0, 31, 1'b1);
    push(16'h0000, 1'b0, 1'b0, 1'b0); send_sub(PRE_W, mk(24'h000000, 1'b0, 1'b0), 0, 31, 1'b1);
    close(1'b1, "t6_locked_jitter");

    check("end_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "bench did not complete");
  end

endmodule
